// File: rtl/quad_step_decoder_if.sv
// Encoder-side signal bundle for quad_step_decoder: raw channels and controls in,
// two_way_counter strobes and error status out.
interface quad_step_decoder_if;
  logic a;
  logic b;
  logic z;
  logic index_en;
  logic err_clr;
  logic up;
  logic enable_b;
  logic set_b;
  logic error;
  logic err_flag;

  modport master (
    output a, b, z, index_en, err_clr,
    input  up, enable_b, set_b, error, err_flag
  );

  modport slave (
    input  a, b, z, index_en, err_clr,
    output up, enable_b, set_b, error, err_flag
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: sync + glitch filter per channel, Gray step decode,
// index load and illegal-transition flagging, producing two_way_counter strobes.
module quad_step_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset_b,
  input  logic raw,
  output logic level
);
  logic       sync1, sync2;
  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 4'd0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= 4'd0;
      end else if (cnt + 4'd1 == 4'(FILTER_LEN)) begin
        level <= ~level;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module quad_step_decoder #(
  parameter int FILTER_LEN = 3,
  parameter int X4         = 1
) (
  input logic               clock,
  input logic               reset_b,
  quad_step_decoder_if.slave bus
);
  localparam int NUM_CH = 3;

  typedef enum logic {SETTLE, TRACK} state_t;

  logic [NUM_CH-1:0] raw, filt;
  logic [1:0]        ab;
  logic              zf;

  assign raw = {bus.a, bus.b, bus.z};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    quad_step_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clock  (clock),
      .reset_b(reset_b),
      .raw    (raw[i]),
      .level  (filt[i])
    );
  end

  assign ab = filt[2:1];
  assign zf = filt[0];

  state_t     state_q, state_d;
  logic [4:0] settle_cnt_q, settle_cnt_d;
  logic [1:0] prev_ab_q, prev_ab_d;
  logic       z_prev_q;
  logic       up_q, up_d, enable_b_q, enable_b_d, set_b_q, set_b_d;
  logic       error_q, error_d, err_flag_q, err_flag_d;

  logic [1:0] delta;
  logic       fwd, illegal, step, step_up, load;

  always_comb begin
    delta = ab ^ prev_ab_q;
    case ({prev_ab_q, ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      default:                             fwd = 1'b0;
    endcase
    illegal = (delta == 2'b11);
    if (X4 != 0) begin
      step    = (delta == 2'b01) || (delta == 2'b10);
      step_up = fwd;
    end else begin
      // Once per cycle: only the 10<->00 edge of channel A counts.
      step    = ({prev_ab_q, ab} == 4'b1000) || ({prev_ab_q, ab} == 4'b0010);
      step_up = (prev_ab_q == 2'b10);
    end
    load = bus.index_en & zf & ~z_prev_q;
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    prev_ab_d    = prev_ab_q;
    up_d         = up_q;
    enable_b_d   = 1'b1;
    set_b_d      = 1'b1;
    error_d      = 1'b0;
    err_flag_d   = bus.err_clr ? 1'b0 : err_flag_q;
    case (state_q)
      SETTLE: begin
        // Wait until the filters have absorbed the power-up position.
        if (settle_cnt_q == 5'(FILTER_LEN + 2)) begin
          prev_ab_d = ab;
          state_d   = TRACK;
        end else begin
          settle_cnt_d = settle_cnt_q + 5'd1;
        end
      end
      TRACK: begin
        prev_ab_d = ab;
        if (illegal) begin
          error_d    = 1'b1;
          err_flag_d = 1'b1;
        end
        if (step) up_d = step_up;
        if (load) begin
          enable_b_d = 1'b0;
          set_b_d    = 1'b0;
        end else if (step) begin
          enable_b_d = 1'b0;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state_q      <= SETTLE;
      settle_cnt_q <= 5'd0;
      prev_ab_q    <= 2'b00;
      z_prev_q     <= 1'b0;
      up_q         <= 1'b0;
      enable_b_q   <= 1'b1;
      set_b_q      <= 1'b1;
      error_q      <= 1'b0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      prev_ab_q    <= prev_ab_d;
      z_prev_q     <= zf;
      up_q         <= up_d;
      enable_b_q   <= enable_b_d;
      set_b_q      <= set_b_d;
      error_q      <= error_d;
      err_flag_q   <= err_flag_d;
    end
  end

  assign bus.up       = up_q;
  assign bus.enable_b = enable_b_q;
  assign bus.set_b    = set_b_q;
  assign bus.error    = error_q;
  assign bus.err_flag = err_flag_q;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench: X4=1 and X4=0 decoders driven from the same encoder stimulus.
module tb_quad_step_decoder;
  logic clock = 1'b0;
  logic reset_b;
  logic a, b, z, index_en, err_clr;

  int checks = 0;
  int errors = 0;

  // Strobe tallies taken at negedge; tests compare deltas against snapshots.
  int n4 = 0, n4u = 0, ns4 = 0, ne4 = 0, n1 = 0, n1u = 0;
  int b4, b4u, bs4, be4, b1, b1u;

  quad_step_decoder_if i4 ();
  quad_step_decoder_if i1 ();

  assign i4.a = a;  assign i4.b = b;  assign i4.z = z;
  assign i4.index_en = index_en;  assign i4.err_clr = err_clr;
  assign i1.a = a;  assign i1.b = b;  assign i1.z = z;
  assign i1.index_en = index_en;  assign i1.err_clr = err_clr;

  quad_step_decoder #(.FILTER_LEN(3), .X4(1)) u_dut4 (
    .clock(clock), .reset_b(reset_b), .bus(i4)
  );
  quad_step_decoder #(.FILTER_LEN(3), .X4(0)) u_dut1 (
    .clock(clock), .reset_b(reset_b), .bus(i1)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_b) begin
      if (!i4.enable_b) begin n4++; if (i4.up) n4u++; end
      if (!i4.set_b) ns4++;
      if (i4.error) ne4++;
      if (!i1.enable_b) begin n1++; if (i1.up) n1u++; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b4 = n4; b4u = n4u; bs4 = ns4; be4 = ne4; b1 = n1; b1u = n1u;
  endtask

  // Called at a negedge: change AB, expect the X4 strobe exactly at edge 5.
  task automatic step_lat(input logic [1:0] ab, input logic exp_up, input string tag);
    a = ab[1]; b = ab[0];
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk({tag, "_pre"}, 32'(i4.enable_b), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_en"}, 32'(i4.enable_b), 32'd0);
    chk({tag, "_up"}, 32'(i4.up), 32'(exp_up));
    repeat (4) @(negedge clock);
  endtask

  initial begin
    reset_b = 1'b0; a = 1'b1; b = 1'b1; z = 1'b0; index_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_up", 32'(i4.up), 32'd0);
    chk("rst_en", 32'(i4.enable_b), 32'd1);
    chk("rst_set", 32'(i4.set_b), 32'd1);
    chk("rst_err", 32'(i4.error), 32'd0);
    chk("rst_flag", 32'(i4.err_flag), 32'd0);
    chk("rst_en1", 32'(i1.enable_b), 32'd1);
    reset_b = 1'b1;
    snap();
    repeat (12) @(negedge clock);
    chk("pwr_nopulse", 32'(n4 - b4), 32'd0);
    chk("pwr_noerr", 32'(ne4 - be4), 32'd0);
    chk("pwr_up", 32'(i4.up), 32'd0);

    step_lat(2'b10, 1'b1, "f11_10");

    snap();
    step_lat(2'b00, 1'b1, "f10_00");
    step_lat(2'b01, 1'b1, "f00_01");
    step_lat(2'b11, 1'b1, "f01_11");
    step_lat(2'b10, 1'b1, "f11_10b");
    chk("fwd_cnt", 32'(n4 - b4), 32'd4);
    chk("fwd_up", 32'(n4u - b4u), 32'd4);
    chk("x1_fwd_cnt", 32'(n1 - b1), 32'd1);
    chk("x1_fwd_up", 32'(n1u - b1u), 32'd1);

    snap();
    step_lat(2'b11, 1'b0, "r10_11");
    step_lat(2'b01, 1'b0, "r11_01");
    step_lat(2'b00, 1'b0, "r01_00");
    step_lat(2'b10, 1'b0, "r00_10");
    chk("rev_cnt", 32'(n4 - b4), 32'd4);
    chk("rev_up", 32'(n4u - b4u), 32'd0);
    chk("x1_rev_cnt", 32'(n1 - b1), 32'd1);
    chk("x1_rev_up", 32'(n1u - b1u), 32'd0);
    chk("x1_up_hold", 32'(i1.up), 32'd0);

    step_lat(2'b00, 1'b1, "f10_00b");

    // Glitch rejection from 00
    snap();
    a = 1'b1; repeat (2) @(negedge clock); a = 1'b0;
    repeat (10) @(negedge clock);
    chk("glitch2_cnt", 32'(n4 - b4), 32'd0);
    chk("glitch2_err", 32'(ne4 - be4), 32'd0);
    snap();
    a = 1'b1; repeat (3) @(negedge clock); a = 1'b0;
    repeat (12) @(negedge clock);
    chk("glitch3_cnt", 32'(n4 - b4), 32'd2);
    chk("glitch3_up", 32'(n4u - b4u), 32'd1);
    chk("glitch3_err", 32'(ne4 - be4), 32'd0);

    // Illegal 00->11
    snap();
    a = 1'b1; b = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("ill_pre", 32'(i4.error), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("ill_err", 32'(i4.error), 32'd1);
    chk("ill_flag", 32'(i4.err_flag), 32'd1);
    chk("ill_en", 32'(i4.enable_b), 32'd1);
    @(negedge clock);
    chk("ill_errpulse", 32'(i4.error), 32'd0);
    err_clr = 1'b1; @(negedge clock); err_clr = 1'b0;
    chk("clr_alone", 32'(i4.err_flag), 32'd0);
    repeat (4) @(negedge clock);
    a = 1'b0; b = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    err_clr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    err_clr = 1'b0;
    chk("clr_vs_set_err", 32'(i4.error), 32'd1);
    chk("clr_vs_set_flag", 32'(i4.err_flag), 32'd1);
    repeat (3) @(negedge clock);
    err_clr = 1'b1; @(negedge clock); err_clr = 1'b0;
    chk("clr_later", 32'(i4.err_flag), 32'd0);
    chk("ill_nstep", 32'(n4 - b4), 32'd0);
    chk("ill_nerr", 32'(ne4 - be4), 32'd2);

    // Index coincident with a forward step 00->01
    repeat (4) @(negedge clock);
    index_en = 1'b1;
    snap();
    z = 1'b1; b = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("idx_pre", 32'(i4.enable_b), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("idx_en", 32'(i4.enable_b), 32'd0);
    chk("idx_set", 32'(i4.set_b), 32'd0);
    chk("idx_up", 32'(i4.up), 32'd1);
    repeat (8) @(negedge clock);
    chk("idx_cnt", 32'(n4 - b4), 32'd1);
    chk("idx_setcnt", 32'(ns4 - bs4), 32'd1);
    z = 1'b0;
    repeat (8) @(negedge clock);
    snap();
    step_lat(2'b00, 1'b0, "idx_r01_00");
    chk("step_noset", 32'(ns4 - bs4), 32'd0);

    index_en = 1'b0;
    snap();
    z = 1'b1;
    repeat (10) @(negedge clock);
    z = 1'b0;
    repeat (8) @(negedge clock);
    chk("idxoff_cnt", 32'(n4 - b4), 32'd0);
    chk("idxoff_set", 32'(ns4 - bs4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage for two_way_counter: turns raw asynchronous quadrature encoder channels (a, b) and an index channel (z) into the counter's control strobes (up, enable_b, set_b).
- Each step produces one clock of enable_b low, with up giving the direction. An index edge produces a load via set_b.
- Illegal Gray transitions are dropped and flagged.
- Outputs connect directly to two_way_counter's up/enable_b/set_b inputs on the same clock.

Parameters:
- FILTER_LEN, 3, consecutive stable synced samples required before a channel's filtered level changes; legal 1..15.
- X4, 1, 1 = count every a/b edge (4 steps per cycle); 0 = count once per cycle (only the AB=10<->00 transition).

Ports:
- clock  input  1  rising-edge system clock.
- reset_b  input  1  synchronous active-low reset.
- a  input  1  encoder channel A, asynchronous.
- b  input  1  encoder channel B, asynchronous.
- z  input  1  encoder index channel, asynchronous.
- index_en  input  1  1 = a z rising edge generates a load.
- err_clr  input  1  synchronous clear of err_flag.
- up  output  1  direction of the current/last step; 1 = forward.
- enable_b  output  1  active-low count/load strobe, one cycle wide.
- set_b  output  1  active-low load strobe; low only together with enable_b.
- error  output  1  one-cycle pulse on an illegal transition.
- err_flag  output  1  sticky error indicator.

Behaviour:
- Reset (reset_b=0 at a rising edge):
  - Outputs: up=0, enable_b=1, set_b=1, error=0, err_flag=0.
  - Internal: sync flops, filtered levels and filter counters cleared; FSM to SETTLE.
- Synchronisers: two flops per channel (a, b, z). No logic on the first flop output.
- Glitch filter, per channel:
  - Counter of width 4.
  - When the synced level equals the filtered level, the counter is cleared.
  - Otherwise the counter increments; on the edge where it would reach FILTER_LEN, the filtered level flips and the counter clears.
  - Pulses shorter than FILTER_LEN cycles never reach the filtered level.
- FSM states:
  - SETTLE: counts FILTER_LEN+2 cycles after reset, then latches prev_ab = filtered AB and moves to TRACK. No strobes are emitted, so a non-00 power-up position is never a step.
  - TRACK:
    - Each cycle, compares filtered AB with prev_ab, then sets prev_ab = filtered AB.
    - Forward Gray order is 00->01->11->10->00; the reverse order is backward.
  - TRACK never leaves except via reset.
- Step decode (TRACK, registered):
  - X4=1: any single-bit change is a step. On the next edge, enable_b=0 for one cycle and up=1 if forward, 0 if backward.
  - X4=0: only 10->00 (up=1) and 00->10 (up=0) step. Other single-bit changes are tracked silently.
  - up holds its last value between steps.
- Illegal transition: both bits change in the same cycle.
  - No step is emitted; error pulses for one cycle; err_flag sets.
  - prev_ab still updates to the new AB.
- err_flag:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr=1 clears it on the next edge.
- Index:
  - Rising edge of filtered z with index_en=1 drives enable_b=0 and set_b=0 for one cycle on the next edge (two_way_counter loads its set value).
  - If a step occurs in the same cycle, the load wins and that step is dropped; up is still updated.
  - A z edge during SETTLE is ignored.
- Latency: a channel change first sampled at edge 0 produces its strobe on edge FILTER_LEN+2 (edge 5 at default).
- Throughput: at most one strobe per cycle. Steps arriving faster than once per FILTER_LEN cycles per channel are not guaranteed.
- Reset mid-operation: any strobe in flight is cancelled on the reset edge; SETTLE is re-entered.

Test Plan:
- Reset held, a=b=1 at release -> no enable_b low pulse ever, up=0; after 5 settle cycles a forward step 11->10 gives enable_b low for 1 cycle with up=1.
- FILTER_LEN=3, X4=1, drive AB 00->01->11->10->00, each held 10 cycles -> exactly 4 enable_b pulses, all up=1, each 5 edges after the input change; the reverse sequence gives 4 pulses with up=0.
- Glitch: pulse a high for 2 cycles from 00 -> no enable_b pulse, no error; a 3-cycle pulse -> one forward and one backward pulse.
- AB 00->11 in one clock -> error high 1 cycle, err_flag=1, no enable_b; err_clr in the same cycle as a new error keeps err_flag=1; a later err_clr alone clears it.
- X4=0, full forward cycle -> one pulse only, at 10->00, up=1; full reverse cycle -> one pulse at 00->10, up=0.
- index_en=1, z rises coincident with a step -> one cycle enable_b=0, set_b=0, no separate step pulse; index_en=0 -> z is ignored.
